// File: rtl/lc3_alu_seq_pkg.sv
// Shared types and constants for the sequential LC-3 style ALU.
package alu_pkg;

    // Operation codes; 11..15 are reserved and execute as PASS.
    typedef enum logic [3:0] {
        OP_PASS = 4'd0,
        OP_ADD  = 4'd1,
        OP_AND  = 4'd2,
        OP_NOT  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SUB  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_t;

    // Control states: waiting, iterating a multiply, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Bit positions inside the {N,Z,P} condition-code vector.
    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    // Condition codes shown while no result has been produced (zero result).
    localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/lc3_alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock,
// WIDTH iterations per product, low WIDTH bits of the product kept.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;

    // Load operands on start, then add/shift once per cycle until the count runs out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                mcand_q  <= a_i;
                mplier_q <= b_i;
                acc_q    <= '0;
                count_q  <= CW'(WIDTH);
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/lc3_alu_seq.sv
// Handshaked LC-3 style ALU: single-cycle logic/arith/shift ops, iterative
// multiply, registered result with NZP, carry and overflow flags.
module lc3_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 5,
    localparam int SHW      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     ra,
    input  logic [WIDTH-1:0]     rb,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 imm_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [2:0]           nzp,
    output logic                 carry,
    output logic                 ovf
);

    localparam int MSB = WIDTH - 1;

    alu_state_t       state_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       nzp_q;
    logic             carry_q;
    logic             ovf_q;

    logic [WIDTH-1:0] opB;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sumAdd;
    logic [WIDTH:0]   sumSub;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             ovf_d;
    logic             accept;
    logic             isMul;
    logic             mulStart;
    logic             mulBusy;
    logic             mulDone;
    logic [WIDTH-1:0] mulProduct;

    // Derive NZP from a result word; exactly one bit is ever set.
    function automatic logic [2:0] nzpOf(input logic [WIDTH-1:0] r);
        logic [2:0] f;
        f        = '0;
        f[NZP_N] = r[MSB];
        f[NZP_Z] = (r == '0);
        f[NZP_P] = !r[MSB] && (r != '0);
        return f;
    endfunction

    assign opB      = imm_sel ? WIDTH'($signed(imm)) : rb;
    assign shamt    = opB[SHW-1:0];
    assign sumAdd   = {1'b0, ra} + {1'b0, opB};
    assign sumSub   = {1'b0, ra} + {1'b0, ~opB} + {{WIDTH{1'b0}}, 1'b1};
    assign accept   = in_valid && in_ready;
    assign isMul    = (op == OP_MUL);
    assign mulStart = accept && isMul;

    // Single-cycle datapath for every op except MUL; flags are zero unless ADD/SUB.
    always_comb begin
        result_d = ra;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (alu_op_t'(op))
            OP_ADD: begin
                result_d = sumAdd[MSB:0];
                carry_d  = sumAdd[WIDTH];
                ovf_d    = (ra[MSB] == opB[MSB]) && (sumAdd[MSB] != ra[MSB]);
            end
            OP_SUB: begin
                result_d = sumSub[MSB:0];
                carry_d  = sumSub[WIDTH];
                ovf_d    = (ra[MSB] != opB[MSB]) && (sumSub[MSB] != ra[MSB]);
            end
            OP_AND:  result_d = ra & opB;
            OP_NOT:  result_d = ~ra;
            OP_OR:   result_d = ra | opB;
            OP_XOR:  result_d = ra ^ opB;
            OP_SHL:  result_d = ra << shamt;
            OP_SHR:  result_d = ra >> shamt;
            OP_SRA:  result_d = $signed(ra) >>> shamt;
            default: result_d = ra;
        endcase
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mulStart),
        .a_i       (ra),
        .b_i       (opB),
        .busy_o    (mulBusy),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    // Control FSM: accepts ops, waits out multiplies, holds results until consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            nzp_q    <= NZP_RESET;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (isMul) begin
                            state_q <= MUL;
                        end else begin
                            result_q <= result_d;
                            nzp_q    <= nzpOf(result_d);
                            carry_q  <= carry_d;
                            ovf_q    <= ovf_d;
                            state_q  <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (mulDone) begin
                        result_q <= mulProduct;
                        nzp_q    <= nzpOf(mulProduct);
                        carry_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (accept && isMul) begin
                            state_q <= MUL;
                        end else if (accept) begin
                            result_q <= result_d;
                            nzp_q    <= nzpOf(result_d);
                            carry_q  <= carry_d;
                            ovf_q    <= ovf_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = !mulBusy && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign nzp       = nzp_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_lc3_alu_seq.sv
// Directed self-checking bench for lc3_alu_seq at WIDTH=16, IMM_WIDTH=5.
module tb_lc3_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [15:0] ra = 16'h0000;
    logic [15:0] rb = 16'h0000;
    logic [4:0]  imm = 5'd0;
    logic        imm_sel = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [2:0]  nzp;
    logic        carry;
    logic        ovf;

    int compared = 0;
    int mismatched = 0;
    int cyc;
    int sawValid;
    int readyLeak;

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    lc3_alu_seq #(
        .WIDTH     (16),
        .IMM_WIDTH (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .ra        (ra),
        .rb        (rb),
        .imm       (imm),
        .imm_sel   (imm_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .nzp       (nzp),
        .carry     (carry),
        .ovf       (ovf)
    );

    // One comparison: count it, and on a miss count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one request at a negedge, let the next posedge accept it, return at the following negedge.
    task automatic applyStimulus(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] im, input logic isel);
        op       = o;
        ra       = a;
        rb       = b;
        imm      = im;
        imm_sel  = isel;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid after a MUL accept, noting any in_ready leak.
    task automatic waitMul(input string tag);
        cyc       = 0;
        readyLeak = 0;
        while (!out_valid && cyc < 24) begin
            if (in_ready) readyLeak = 1;
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_in_time"}, 32'(cyc <= 17 && out_valid), 32'd1);
        checkOutput({tag, "_busy_not_ready"}, 32'(readyLeak), 32'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_nzp", 32'(nzp), 32'b010);
        checkOutput("rst_result", 32'(result), 32'h0000);
        checkOutput("rst_flags", 32'({carry, ovf}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD with sign-extended immediate, signed overflow
        applyStimulus(OP_ADD, 16'h7FFF, 16'h0000, 5'b00001, 1'b1);
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_result", 32'(result), 32'h8000);
        checkOutput("add_nzp", 32'(nzp), 32'b100);
        checkOutput("add_ovf", 32'(ovf), 32'd1);
        checkOutput("add_carry", 32'(carry), 32'd0);
        @(negedge clk);
        checkOutput("add_drain", 32'(out_valid), 32'd0);

        // SUB equal operands: zero, no borrow
        applyStimulus(OP_SUB, 16'h0005, 16'h0005, 5'd0, 1'b0);
        checkOutput("sub_result", 32'(result), 32'h0000);
        checkOutput("sub_nzp", 32'(nzp), 32'b010);
        checkOutput("sub_carry", 32'(carry), 32'd1);
        checkOutput("sub_ovf", 32'(ovf), 32'd0);
        @(negedge clk);

        // AND held under back-pressure; a request during the stall is ignored
        out_ready = 1'b0;
        applyStimulus(OP_AND, 16'hF0F0, 16'h0FF0, 5'd0, 1'b0);
        op = OP_PASS; ra = 16'h1111; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("and_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("and_hold_result", 32'(result), 32'h00F0);
            checkOutput("and_hold_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput("and_nzp", 32'(nzp), 32'b001);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("and_drain", 32'(out_valid), 32'd0);

        // Immediate sign extension through OR: imm 10000 -> 0xFFF0
        applyStimulus(OP_OR, 16'h0100, 16'h0000, 5'b10000, 1'b1);
        checkOutput("or_imm_result", 32'(result), 32'hFFF0);
        @(negedge clk);

        // MUL 0x13 * 7 = 0x85
        applyStimulus(OP_MUL, 16'h0013, 16'h0007, 5'd0, 1'b0);
        waitMul("mul1");
        checkOutput("mul1_result", 32'(result), 32'h0085);
        checkOutput("mul1_nzp", 32'(nzp), 32'b001);
        checkOutput("mul1_flags", 32'({carry, ovf}), 32'd0);
        @(negedge clk);

        // MUL 0xFFFF * 0xFFFF keeps low word 0x0001
        applyStimulus(OP_MUL, 16'hFFFF, 16'hFFFF, 5'd0, 1'b0);
        waitMul("mul2");
        checkOutput("mul2_result", 32'(result), 32'h0001);
        @(negedge clk);

        // Shifts by register amount
        applyStimulus(OP_SRA, 16'h8000, 16'h0004, 5'd0, 1'b0);
        checkOutput("sra_result", 32'(result), 32'hF800);
        checkOutput("sra_nzp", 32'(nzp), 32'b100);
        @(negedge clk);
        applyStimulus(OP_SHR, 16'h8000, 16'h0004, 5'd0, 1'b0);
        checkOutput("shr_result", 32'(result), 32'h0800);
        @(negedge clk);
        applyStimulus(OP_SHL, 16'h0001, 16'h000F, 5'd0, 1'b0);
        checkOutput("shl_result", 32'(result), 32'h8000);
        @(negedge clk);
        applyStimulus(OP_SHL, 16'h1234, 16'h0000, 5'd0, 1'b0);
        checkOutput("shl0_result", 32'(result), 32'h1234);
        @(negedge clk);

        // Reserved opcode behaves as PASS
        applyStimulus(4'd12, 16'hABCD, 16'h0001, 5'd0, 1'b0);
        checkOutput("rsvd_result", 32'(result), 32'hABCD);
        checkOutput("rsvd_nzp", 32'(nzp), 32'b100);
        @(negedge clk);

        // Back-to-back streaming: PASS, XOR, NOT on consecutive cycles
        op = OP_PASS; ra = 16'h1234; rb = 16'h0000; imm_sel = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2b_pass", 32'({out_valid, result}), 32'h1_1234);
        checkOutput("b2b_ready", 32'(in_ready), 32'd1);
        op = OP_XOR; ra = 16'h1234; rb = 16'h00FF;
        @(negedge clk);
        checkOutput("b2b_xor", 32'({out_valid, result}), 32'h1_12CB);
        op = OP_NOT; ra = 16'h00FF;
        @(negedge clk);
        checkOutput("b2b_not", 32'({out_valid, result}), 32'h1_FF00);
        checkOutput("b2b_not_nzp", 32'(nzp), 32'b100);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_drain", 32'(out_valid), 32'd0);

        // Reset during a multiply discards it
        applyStimulus(OP_MUL, 16'h0003, 16'h0005, 5'd0, 1'b0);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_result", 32'(result), 32'h0000);
        checkOutput("midrst_nzp", 32'(nzp), 32'b010);
        @(negedge clk);
        reset = 1'b0;
        sawValid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1;
        end
        checkOutput("midrst_no_result", 32'(sawValid), 32'd0);

        // Normal operation after reset: wrap to zero with carry
        applyStimulus(OP_ADD, 16'hFFFF, 16'h0001, 5'd0, 1'b0);
        checkOutput("post_add_result", 32'(result), 32'h0000);
        checkOutput("post_add_flags", 32'({nzp, carry, ovf}), 32'b010_1_0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
